// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports and the shared memory bus seen by data_memory_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface data_memory_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_read, mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_read, mem_write, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port, big-endian data memory.
// Misaligned or out-of-range accesses are answered with err and never reach the memory.
module data_memory_arbiter #(
  parameter int unsigned MEM_BYTES   = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  data_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        any_req;
  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] last_byte;
  logic        illegal;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    any_req   = bus.p0_req | bus.p1_req;
    win       = (bus.p0_req & bus.p1_req) ? ptr_q : bus.p1_req;
    sel_we    = win ? bus.p1_we : bus.p0_we;
    sel_addr  = win ? bus.p1_addr : bus.p0_addr;
    sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    last_byte = {1'b0, sel_addr} + 33'd3;
    illegal   = (sel_addr[1:0] != 2'b00) || (last_byte >= 33'(MEM_BYTES));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = win;
          ptr_d   = ~win;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = illegal;
          rdata_d = '0;
          cnt_d   = CntInit;
          state_d = illegal ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          rdata_d = we_q ? '0 : bus.mem_read_data;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  logic idle;
  logic resp;

  // Grants are gated by reset directly so they drop without waiting for the state register.
  always_comb begin
    idle               = (state_q == StIdle);
    resp               = (state_q == StResp);
    bus.p0_gnt         = idle && !reset && any_req && !win;
    bus.p1_gnt         = idle && !reset && any_req && win;
    bus.mem_read       = (state_q == StAccess) && !we_q;
    bus.mem_write      = (state_q == StAccess) && we_q;
    bus.mem_address    = addr_q;
    bus.mem_write_data = wdata_q;
    bus.p0_rvalid      = resp && !owner_q;
    bus.p1_rvalid      = resp && owner_q;
    bus.p0_rdata       = bus.p0_rvalid ? rdata_q : '0;
    bus.p1_rdata       = bus.p1_rvalid ? rdata_q : '0;
    bus.p0_err         = bus.p0_rvalid && err_q;
    bus.p1_err         = bus.p1_rvalid && err_q;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Two-port arbiter and sequencer for the shared single-port, byte-addressed, big-endian data memory.
- Port 0 is the CPU load/store stage; port 1 is the debug/DMA loader.
- Grants one requester at a time using round-robin. Drives the memory read/write strobes for a fixed number of cycles, then returns a registered response.
- Rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 32, size of the memory in bytes. Valid word addresses satisfy addr+3 < MEM_BYTES.
- WAIT_CYCLES, 1, number of cycles mem_read/mem_write stay asserted per access. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held high until granted
- p0_we  in  1  port 0 write enable (1 = store, 0 = load)
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 store data
- p0_gnt  out  1  port 0 request accepted this cycle (combinational)
- p0_rvalid  out  1  port 0 response pulse (one cycle)
- p0_rdata  out  32  port 0 load data, valid while p0_rvalid is high
- p0_err  out  1  port 0 access rejected, valid while p0_rvalid is high
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  32  memory byte address
- mem_write_data  out  32  memory write data
- mem_read_data  in  32  memory read data (combinational from memory)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FSM goes to IDLE and the priority pointer points to port 0.
  - All outputs go to 0: strobes, mem_address, mem_write_data, all gnt/rvalid/rdata/err.
- Reset during ACCESS or RESP:
  - Strobes drop immediately and the transaction is aborted.
  - No response is issued for it; requesters must re-request.
- FSM states:
  - IDLE: arbitrate. The granted request's we, addr and wdata are captured into registers at the clock edge.
    - Capture is illegal (address misaligned when addr[1:0] != 0, or addr+3 >= MEM_BYTES): go to RESP with err=1.
    - Otherwise go to ACCESS.
  - ACCESS: mem_read = !we or mem_write = we, held for exactly WAIT_CYCLES cycles. A down-counter tracks the cycles.
    - mem_address and mem_write_data equal the captured values and are stable for the whole state.
    - On the last ACCESS edge, mem_read_data is registered into the response data (loads only).
    - Then go to RESP.
  - RESP: rvalid=1 for exactly one cycle on the owning port only. rdata = loaded word for loads, 0 for stores and errors. err as determined at capture. Then go to IDLE.
- Strobes and timing:
  - Strobes are low in IDLE and RESP, so each access produces a fresh strobe edge.
  - The memory never sees both strobes high at once.
- Arbitration (IDLE only):
  - Only one port requests: that port wins.
  - Both request: the port named by the pointer wins.
  - The pointer moves to the other port after every accepted request, including errored ones.
  - pX_gnt is high only in IDLE, for the winning requester only, and never while reset is high.
- Latency:
  - Request accepted at edge T: strobes in cycles T+1..T+WAIT_CYCLES, rvalid in cycle T+WAIT_CYCLES+1.
  - Next acceptance is at the earliest at edge T+WAIT_CYCLES+2.
  - Error path: rvalid in cycle T+1, no strobes.
- Requests held during ACCESS or RESP are not granted and are not lost. They win arbitration at the next IDLE according to the pointer.
- Address widths: the full 32-bit address is compared for the range check. No wrap-around; addresses that would exceed MEM_BYTES-1 are errors.

Test Plan:
- Store, then load: p0 store addr=0x4 data=0xDEADBEEF, then p0 load addr=0x4 (WAIT_CYCLES=1).
  - Store: mem_write high one cycle at 0x4, rvalid at T+2, err=0, rdata=0.
  - Load: p0_rdata=0xDEADBEEF.
- Contention: p0 and p1 both load 0x0 in the same cycle after reset.
  - p0 granted first, p1 granted at T+3.
  - Pointer then favours p0 again, and p0/p1 alternate under continuous requests.
- Errors: p1 loads addr=0x2 (misaligned) and addr=0x1C+4=0x20 (out of range).
  - Each gives p1_rvalid=1, p1_err=1, p1_rdata=0 one cycle after grant.
  - No strobe asserted; pointer still toggles.
- WAIT_CYCLES=3: p0 load addr=0xC with memory preloaded with 0x00000008.
  - mem_read high for exactly 3 cycles with stable address.
  - rvalid at T+4 with rdata=0x00000008.
- Reset mid-ACCESS: assert reset during the 2nd strobe cycle (WAIT_CYCLES=3).
  - Strobes and all outputs are 0 immediately, no rvalid.
  - After release, FSM is in IDLE, pointer is at p0, and a fresh request completes normally.
